decimation_ctrl: RTL and testbench

Scan controller for the factor-2^SHIFT_FACTOR decimation datapath. On START it walks every output coordinate in raster order, drives the datapath's X_OUT_COORD/Y_OUT_COORD, tracks the source-memory read latency, and writes each returned pixel into the output frame buffer at the packed output address. It sits between the control/register front end (START/BUSY/DONE) and the decimation datapath plus source ROM and destination RAM.

---
 rtl/decimation_ctrl.sv | 146 ++++++++++++++
 tb/tb_decimation_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decimation_ctrl.sv
// decimation_ctrl: raster scan controller for the 2^SHIFT_FACTOR decimator.
// Walks output coordinates, tracks source read latency, writes dest RAM.
//
// Ports:
//   CLK, RESET (async, active-high), START    control front end
//   BUSY, DONE                                 frame status
//   X_OUT_COORD, Y_OUT_COORD                   coordinates to datapath
//   PIXEL_IN                                   pixel from datapath
//   W_EN, W_ADDR, W_DATA                       destination RAM write port
//   ABORT                                      only with DECIM_ABORT_EN
//
// Optional feature macro: DECIM_ABORT_EN (adds ABORT to cancel a frame).
module decimation_ctrl #(
    parameter int IMG_WIDTH_IN  = 160,
    parameter int IMG_HEIGHT_IN = 120,
    parameter int SHIFT_FACTOR  = 1,
    parameter int RD_LATENCY    = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
`ifdef DECIM_ABORT_EN
    input  logic        ABORT,
`endif
    output logic        BUSY,
    output logic        DONE,
    output logic [8:0]  X_OUT_COORD,
    output logic [7:0]  Y_OUT_COORD,
    input  logic [7:0]  PIXEL_IN,
    output logic        W_EN,
    output logic [14:0] W_ADDR,
    output logic [7:0]  W_DATA
);

    localparam int OUT_W = IMG_WIDTH_IN >> SHIFT_FACTOR;
    localparam int OUT_H = IMG_HEIGHT_IN >> SHIFT_FACTOR;
    localparam int DEPTH = RD_LATENCY + 1;
    localparam logic [8:0] X_LAST = 9'(OUT_W - 1);
    localparam logic [7:0] Y_LAST = 8'(OUT_H - 1);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN,
        FIN
    } state_t;

    state_t      state;
    logic [14:0] addr_cnt;
    logic        abort_req;

    // Entry k holds the write tag of the coordinate issued k edges ago;
    // the tail lines up with the cycle in which PIXEL_IN is valid.
    logic [DEPTH-1:0] vp_valid;
    logic [14:0]      vp_addr [DEPTH];

`ifdef DECIM_ABORT_EN
    assign abort_req = ABORT;
`else
    assign abort_req = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state       <= IDLE;
            BUSY        <= 1'b0;
            DONE        <= 1'b0;
            X_OUT_COORD <= '0;
            Y_OUT_COORD <= '0;
            W_EN        <= 1'b0;
            W_ADDR      <= '0;
            W_DATA      <= '0;
            addr_cnt    <= '0;
            vp_valid    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                vp_addr[i] <= '0;
            end
        end else begin
            vp_valid <= {vp_valid[DEPTH-2:0], 1'b0};
            for (int i = 1; i < DEPTH; i++) begin
                vp_addr[i] <= vp_addr[i-1];
            end
            W_EN <= vp_valid[DEPTH-1];
            if (vp_valid[DEPTH-1]) begin
                W_ADDR <= vp_addr[DEPTH-1];
                W_DATA <= PIXEL_IN;
            end
            DONE <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (START) begin
                        state       <= SCAN;
                        BUSY        <= 1'b1;
                        X_OUT_COORD <= '0;
                        Y_OUT_COORD <= '0;
                        vp_valid[0] <= 1'b1;
                        vp_addr[0]  <= '0;
                        addr_cnt    <= 15'd1;
                    end
                end
                SCAN: begin
                    if (abort_req) begin
                        state    <= IDLE;
                        BUSY     <= 1'b0;
                        W_EN     <= 1'b0;
                        vp_valid <= '0;
                    end else if (X_OUT_COORD == X_LAST &&
                                 Y_OUT_COORD == Y_LAST) begin
                        state <= DRAIN;
                    end else begin
                        if (X_OUT_COORD == X_LAST) begin
                            X_OUT_COORD <= '0;
                            Y_OUT_COORD <= Y_OUT_COORD + 8'd1;
                        end else begin
                            X_OUT_COORD <= X_OUT_COORD + 9'd1;
                        end
                        vp_valid[0] <= 1'b1;
                        vp_addr[0]  <= addr_cnt;
                        addr_cnt    <= addr_cnt + 15'd1;
                    end
                end
                DRAIN: begin
                    if (abort_req) begin
                        state    <= IDLE;
                        BUSY     <= 1'b0;
                        W_EN     <= 1'b0;
                        vp_valid <= '0;
                    end else if (vp_valid == '0) begin
                        // last write has left the tail on the previous edge
                        state <= FIN;
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decimation_ctrl.sv
// tb_decimation_ctrl: directed bench for decimation_ctrl.
// Three instances: 8x4 lat 1, 8x4 lat 3, default 160x120.
module tb_decimation_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [2:0]  st;
    logic [2:0]  abort;
    logic [2:0]  busy;
    logic [2:0]  done;
    logic [2:0]  wen;
    logic [8:0]  xo    [3];
    logic [7:0]  yo    [3];
    logic [7:0]  pix   [3];
    logic [14:0] waddr [3];
    logic [7:0]  wdata [3];

    int tests = 0;
    int failed = 0;

    decimation_ctrl #(
        .IMG_WIDTH_IN(8), .IMG_HEIGHT_IN(4),
        .SHIFT_FACTOR(1), .RD_LATENCY(1)
    ) u1 (
        .CLK(clk), .RESET(rst), .START(st[0]),
`ifdef DECIM_ABORT_EN
        .ABORT(abort[0]),
`endif
        .BUSY(busy[0]), .DONE(done[0]),
        .X_OUT_COORD(xo[0]), .Y_OUT_COORD(yo[0]),
        .PIXEL_IN(pix[0]), .W_EN(wen[0]),
        .W_ADDR(waddr[0]), .W_DATA(wdata[0])
    );

    decimation_ctrl #(
        .IMG_WIDTH_IN(8), .IMG_HEIGHT_IN(4),
        .SHIFT_FACTOR(1), .RD_LATENCY(3)
    ) u3 (
        .CLK(clk), .RESET(rst), .START(st[1]),
`ifdef DECIM_ABORT_EN
        .ABORT(abort[1]),
`endif
        .BUSY(busy[1]), .DONE(done[1]),
        .X_OUT_COORD(xo[1]), .Y_OUT_COORD(yo[1]),
        .PIXEL_IN(pix[1]), .W_EN(wen[1]),
        .W_ADDR(waddr[1]), .W_DATA(wdata[1])
    );

    decimation_ctrl ud (
        .CLK(clk), .RESET(rst), .START(st[2]),
`ifdef DECIM_ABORT_EN
        .ABORT(abort[2]),
`endif
        .BUSY(busy[2]), .DONE(done[2]),
        .X_OUT_COORD(xo[2]), .Y_OUT_COORD(yo[2]),
        .PIXEL_IN(pix[2]), .W_EN(wen[2]),
        .W_ADDR(waddr[2]), .W_DATA(wdata[2])
    );

    // Datapath model: pixel = x + 16*y (mod 256), delayed by RD_LATENCY.
    function automatic logic [7:0] fpix(logic [8:0] x, logic [7:0] y);
        return x[7:0] + {y[3:0], 4'b0000};
    endfunction

    function automatic int exp_data(int a, int ow);
        return ((a % ow) + 16 * (a / ow)) & 255;
    endfunction

    logic [7:0] p0, p2;
    logic [7:0] d3 [3];
    always @(posedge clk) begin
        p0    <= fpix(xo[0], yo[0]);
        p2    <= fpix(xo[2], yo[2]);
        d3[0] <= fpix(xo[1], yo[1]);
        d3[1] <= d3[0];
        d3[2] <= d3[1];
    end
    assign pix[0] = p0;
    assign pix[1] = d3[2];
    assign pix[2] = p2;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full frame on instance id: N pixels, latency lat, output width ow.
    task automatic run_frame(input int id, input int n, input int lat,
                             input int ow, input string tag);
        int wen_err = 0;
        int addr_err = 0;
        int data_err = 0;
        int busy_err = 0;
        int wcnt = 0;
        int dcnt = 0;
        int dcyc = -1;
        int last = -1;
        bit ew;
        st[id] = 1'b1;
        tick();
        st[id] = 1'b0;
        for (int c = 1; c <= n + lat + 3; c++) begin
            ew = (c >= lat + 2) && (c <= n + lat + 1);
            if (wen[id] != ew) wen_err++;
            if (wen[id]) begin
                wcnt++;
                last = int'(waddr[id]);
            end
            if (ew) begin
                if (int'(waddr[id]) != c - lat - 2) addr_err++;
                if (int'(wdata[id]) != exp_data(c - lat - 2, ow))
                    data_err++;
            end
            if (done[id]) begin
                dcnt++;
                dcyc = c;
            end
            if (busy[id] != (c <= n + lat + 1)) busy_err++;
            tick();
        end
        chk({tag, " wen_pattern_errs"}, wen_err, 0);
        chk({tag, " addr_errs"}, addr_err, 0);
        chk({tag, " data_errs"}, data_err, 0);
        chk({tag, " busy_errs"}, busy_err, 0);
        chk({tag, " write_count"}, wcnt, n);
        chk({tag, " last_addr"}, last, n - 1);
        chk({tag, " done_count"}, dcnt, 1);
        chk({tag, " done_cycle"}, dcyc, n + lat + 2);
    endtask

    typedef struct {
        int x;
        int y;
        int busy;
        int wen;
        int addr;
        int data;
        int done;
    } vec_t;

    vec_t tbl [12];

    initial begin
        int wc;
        int dc;
        int dcyc;
        bit got;

        tbl[0]  = '{0, 0, 1, 0, 0, 0, 0};
        tbl[1]  = '{1, 0, 1, 0, 0, 0, 0};
        tbl[2]  = '{2, 0, 1, 1, 0, 0, 0};
        tbl[3]  = '{3, 0, 1, 1, 1, 1, 0};
        tbl[4]  = '{0, 1, 1, 1, 2, 2, 0};
        tbl[5]  = '{1, 1, 1, 1, 3, 3, 0};
        tbl[6]  = '{2, 1, 1, 1, 4, 16, 0};
        tbl[7]  = '{3, 1, 1, 1, 5, 17, 0};
        tbl[8]  = '{3, 1, 1, 1, 6, 18, 0};
        tbl[9]  = '{3, 1, 1, 1, 7, 19, 0};
        tbl[10] = '{3, 1, 0, 0, 0, 0, 1};
        tbl[11] = '{3, 1, 0, 0, 0, 0, 0};

        rst = 1'b1;
        st = '0;
        abort = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst busy", int'(busy[0]), 0);
        chk("rst done", int'(done[0]), 0);
        chk("rst wen", int'(wen[0]), 0);
        chk("rst waddr", int'(waddr[0]), 0);
        chk("rst wdata", int'(wdata[0]), 0);
        chk("rst x", int'(xo[0]), 0);
        chk("rst y", int'(yo[0]), 0);
        rst = 1'b0;
        tick();

        // Table-driven 4x2 frame, latency 1
        st[0] = 1'b1;
        tick();
        st[0] = 1'b0;
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("tbl c%0d x", i + 1), int'(xo[0]), tbl[i].x);
            chk($sformatf("tbl c%0d y", i + 1), int'(yo[0]), tbl[i].y);
            chk($sformatf("tbl c%0d busy", i + 1), int'(busy[0]),
                tbl[i].busy);
            chk($sformatf("tbl c%0d wen", i + 1), int'(wen[0]), tbl[i].wen);
            chk($sformatf("tbl c%0d done", i + 1), int'(done[0]),
                tbl[i].done);
            if (tbl[i].wen != 0) begin
                chk($sformatf("tbl c%0d waddr", i + 1), int'(waddr[0]),
                    tbl[i].addr);
                chk($sformatf("tbl c%0d wdata", i + 1), int'(wdata[0]),
                    tbl[i].data);
            end
            tick();
        end

        // Latency 3: writes in cycles 5..12, DONE in 13
        run_frame(1, 8, 3, 4, "lat3");

        // START held high across the whole frame
        st[0] = 1'b1;
        tick();
        wc = 0;
        dc = 0;
        dcyc = -1;
        for (int c = 1; c <= 13; c++) begin
            if (c <= 12) begin
                wc += int'(wen[0]);
                if (done[0]) begin
                    dc++;
                    dcyc = c;
                end
            end
            if (c == 11 || c == 12)
                chk($sformatf("hold c%0d busy", c), int'(busy[0]), 0);
            if (c == 13) begin
                chk("hold restart busy", int'(busy[0]), 1);
                chk("hold restart x", int'(xo[0]), 0);
                chk("hold restart y", int'(yo[0]), 0);
                chk("hold restart wen", int'(wen[0]), 0);
            end else begin
                tick();
            end
        end
        st[0] = 1'b0;
        chk("hold write_count", wc, 8);
        chk("hold done_count", dc, 1);
        chk("hold done_cycle", dcyc, 11);
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            tick();
            got = done[0];
        end
        chk("hold second done seen", int'(got), 1);
        tick();

        // Reset asserted in cycle 5 of a frame
        st[0] = 1'b1;
        tick();
        st[0] = 1'b0;
        for (int c = 1; c < 5; c++) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("mid rst busy", int'(busy[0]), 0);
        chk("mid rst wen", int'(wen[0]), 0);
        chk("mid rst waddr", int'(waddr[0]), 0);
        chk("mid rst wdata", int'(wdata[0]), 0);
        chk("mid rst x", int'(xo[0]), 0);
        chk("mid rst y", int'(yo[0]), 0);
        chk("mid rst done", int'(done[0]), 0);
        tick();
        rst = 1'b0;
        wc = 0;
        dc = 0;
        for (int c = 0; c < 15; c++) begin
            wc += int'(wen[0]);
            dc += int'(done[0]);
            tick();
        end
        chk("post rst wen_count", wc, 0);
        chk("post rst done_count", dc, 0);
        run_frame(0, 8, 1, 4, "after_rst");

`ifdef DECIM_ABORT_EN
        // ABORT raised in cycle 4 of a frame
        st[0] = 1'b1;
        tick();
        st[0] = 1'b0;
        for (int c = 1; c < 4; c++) tick();
        abort[0] = 1'b1;
        tick();
        abort[0] = 1'b0;
        chk("abort wen", int'(wen[0]), 0);
        chk("abort busy", int'(busy[0]), 0);
        wc = 0;
        dc = 0;
        for (int c = 0; c < 12; c++) begin
            wc += int'(wen[0]);
            dc += int'(done[0]);
            tick();
        end
        chk("abort wen_count", wc, 0);
        chk("abort done_count", dc, 0);
        run_frame(0, 8, 1, 4, "after_abort");
`endif

        // Default 160x120: 4800 writes, DONE in cycle 4803
        run_frame(2, 4800, 1, 80, "full");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
